// File: rtl/mcoc_fetch_pfq_pkg.sv
// Shared widths, defaults and types for the instruction prefetch queue.
// Count width leaves room for a completely full queue (0..QDEPTH).
package mcoc_fetch_pkg;
   localparam int          QDEPTH_DEF = 4;
   localparam logic [15:0] RSTVEC_DEF = 16'h0000;
   localparam int          HW_W       = 16;
   localparam int          AW         = 16;

   function automatic int cnt_width(int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int CNT_W = cnt_width(QDEPTH_DEF);

   typedef logic [HW_W-1:0] hword_t;
   typedef logic [AW-1:0]   addr_t;
endpackage

// File: rtl/mcoc_fetch_pfq_if.sv
// Program-memory fetch port plus the halfword delivery port towards the decoder.
interface mcoc_fetch_pfq_if;
   import mcoc_fetch_pkg::*;

   logic         fen;
   logic         fcmdl;
   addr_t        fadr;
   logic [31:0]  fdat;
   logic         jmp;
   addr_t        jadr;
   logic         ivld;
   logic         irdy;
   hword_t       idat;
   addr_t        iadr;

   modport master (
      output fen, fcmdl, fadr, ivld, idat, iadr,
      input  fdat, jmp, jadr, irdy
   );

   modport slave (
      input  fen, fcmdl, fadr, ivld, idat, iadr,
      output fdat, jmp, jadr, irdy
   );
endinterface

// File: rtl/mcoc_pfq_fifo.sv
// Halfword FIFO: writes 0, 1 or 2 entries per cycle, reads at most one.
// Flush wins over push/pop; the caller guarantees no overflow or empty pop.
module mcoc_pfq_fifo
   import mcoc_fetch_pkg::*;
#(
   parameter int DEPTH = QDEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic [1:0]                  push_n_i,
   input  hword_t                      push0_i,
   input  hword_t                      push1_i,
   input  logic                        pop_i,
   output hword_t                      head_o,
   output logic [cnt_width(DEPTH)-1:0] cnt_o
);
   localparam int CW = cnt_width(DEPTH);
   localparam int PW = $clog2(DEPTH);

   hword_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_q;
   logic [PW-1:0]   rd_q;
   logic [PW-1:0]   wr1;
   logic [CW-1:0]   cnt_q;

   assign wr1 = wr_q + PW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_n_i != 2'd0) begin
            mem_q[wr_q] <= push0_i;
         end
         if (push_n_i == 2'd2) begin
            mem_q[wr1] <= push1_i;
         end
         wr_q  <= wr_q + PW'(push_n_i);
         rd_q  <= rd_q + PW'(pop_i);
         cnt_q <= cnt_q + CW'(push_n_i) - CW'(pop_i);
      end
   end

   assign head_o = mem_q[rd_q];
   assign cnt_o  = cnt_q;
endmodule

// File: rtl/mcoc_fetch_pfq.sv
// Prefetch queue: 32-bit word fetches (1-cycle read latency) split into halfwords, upper first.
// Redirect flushes the queue and drops the fetch still returning; fetch only issues if it surely fits.
module mcoc_fetch_pfq
   import mcoc_fetch_pkg::*;
#(
   parameter int          QDEPTH = QDEPTH_DEF,
   parameter logic [15:0] RSTVEC = RSTVEC_DEF
) (
   input logic               clk,
   input logic               rst_n,
   mcoc_fetch_pfq_if.master  pfq_if
);
   localparam int CW = cnt_width(QDEPTH);

   addr_t           fpc_q, fpc_d;
   addr_t           hpc_q, hpc_d;
   logic            inflight_q;
   logic            skip_q, skip_d;
   logic            squash_q;
   logic [CW-1:0]   cnt;
   hword_t          head;
   logic [CW:0]     demand;
   logic            issue;
   logic            ret;
   logic            pop;
   logic [1:0]      push_n;

   // Occupancy plus the two halfwords a pending fetch may still deliver.
   always_comb begin
      demand = (CW+1)'(cnt) + (inflight_q ? (CW+1)'(2) : (CW+1)'(0));
      issue  = rst_n & ~pfq_if.jmp & (demand <= (CW+1)'(QDEPTH - 2));
      ret    = inflight_q & ~squash_q & ~pfq_if.jmp;
      push_n = ret ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
      pop    = (cnt != '0) & pfq_if.irdy & ~pfq_if.jmp;
   end

   always_comb begin
      fpc_d  = fpc_q;
      hpc_d  = hpc_q;
      skip_d = skip_q;
      if (pfq_if.jmp) begin
         fpc_d  = pfq_if.jadr & 16'hFFFC;
         hpc_d  = pfq_if.jadr & 16'hFFFE;
         skip_d = pfq_if.jadr[1];
      end else begin
         if (issue) begin
            fpc_d = fpc_q + 16'd4;
         end
         if (pop) begin
            hpc_d = hpc_q + 16'd2;
         end
         if (ret && skip_q) begin
            skip_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc_q      <= RSTVEC;
         hpc_q      <= RSTVEC;
         inflight_q <= 1'b0;
         skip_q     <= RSTVEC[1];
         squash_q   <= 1'b0;
      end else begin
         fpc_q      <= fpc_d;
         hpc_q      <= hpc_d;
         inflight_q <= issue;
         skip_q     <= skip_d;
         squash_q   <= pfq_if.jmp & (inflight_q | issue);
      end
   end

   mcoc_pfq_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (pfq_if.jmp),
      .push_n_i (push_n),
      .push0_i  (skip_q ? pfq_if.fdat[15:0] : pfq_if.fdat[31:16]),
      .push1_i  (pfq_if.fdat[15:0]),
      .pop_i    (pop),
      .head_o   (head),
      .cnt_o    (cnt)
   );

   assign pfq_if.fen   = issue;
   assign pfq_if.fcmdl = 1'b1;
   assign pfq_if.fadr  = fpc_q & 16'hFFFC;
   assign pfq_if.ivld  = (cnt != '0);
   assign pfq_if.idat  = head;
   assign pfq_if.iadr  = hpc_q;
endmodule

// File: tb/tb_mcoc_fetch_pfq.sv
// Bench for mcoc_fetch_pfq: ROM model, halfword stream scoreboard and directed/random scenarios.
module tb_mcoc_fetch_pfq;
   import mcoc_fetch_pkg::*;

   localparam logic [15:0] RV = 16'h0000;
   localparam int          QD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mcoc_fetch_pfq_if bus();

   mcoc_fetch_pfq #(.QDEPTH(QD), .RSTVEC(RV)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pfq_if (bus)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          mon_chk = 0;
   int          mon_pass = 0;
   int          n_acc = 0;
   logic [15:0] exp_pc = RV;

   function automatic logic [31:0] rom_word(input logic [15:0] a);
      case (a)
         16'h0000: return 32'h11112222;
         16'h0004: return 32'h33334444;
         16'h0010: return 32'hAAAABBBB;
         default:  return {a ^ 16'hC35A, ~a};
      endcase
   endfunction

   function automatic logic [15:0] rom_hw(input logic [15:0] a);
      logic [31:0] w;
      w = rom_word(a & 16'hFFFC);
      return a[1] ? w[15:0] : w[31:16];
   endfunction

   // Memory answers one cycle after the strobe; otherwise drives garbage.
   always @(posedge clk) begin
      bus.fdat <= bus.fen ? rom_word(bus.fadr) : 32'($urandom);
   end

   // Stream scoreboard: every accepted halfword must be the next one of the program.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc = RV;
      end else begin
         if (bus.fen) begin
            mon_chk++;
            if (bus.fadr[1:0] !== 2'b00 || bus.fcmdl !== 1'b1)
               $display("FAIL fetch_port: fadr=%h fcmdl=%b want aligned and 1", bus.fadr, bus.fcmdl);
            else
               mon_pass++;
         end
         if (bus.jmp) begin
            exp_pc = bus.jadr & 16'hFFFE;
         end else if (bus.ivld && bus.irdy) begin
            mon_chk++;
            if (bus.iadr !== exp_pc || bus.idat !== rom_hw(exp_pc))
               $display("FAIL stream: got %h@%h want %h@%h", bus.idat, bus.iadr, rom_hw(exp_pc), exp_pc);
            else
               mon_pass++;
            exp_pc = exp_pc + 16'd2;
            n_acc++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [15:0] exp_d [4];
      exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      rst_n = 1'b0; bus.jmp = 1'b0; bus.jadr = '0; bus.irdy = 1'b0;
      cyc(3);
      n_chk++; if (bus.fen !== 1'b0) $display("FAIL reset_fen: got %b want 0", bus.fen); else n_pass++;
      n_chk++; if (bus.ivld !== 1'b0) $display("FAIL reset_ivld: got %b want 0", bus.ivld); else n_pass++;
      n_chk++; if (bus.idat !== 16'h0) $display("FAIL reset_idat: got %h want 0000", bus.idat); else n_pass++;
      n_chk++; if (bus.iadr !== RV) $display("FAIL reset_iadr: got %h want %h", bus.iadr, RV); else n_pass++;
      n_chk++; if (bus.fcmdl !== 1'b1) $display("FAIL reset_fcmdl: got %b want 1", bus.fcmdl); else n_pass++;
      rst_n = 1'b1; bus.irdy = 1'b1; #1;
      n_chk++;
      if (bus.fen !== 1'b1 || bus.fadr !== RV)
         $display("FAIL first_fetch: fen=%b fadr=%h want 1/%h", bus.fen, bus.fadr, RV);
      else n_pass++;
      cyc(1);
      n_chk++; if (bus.ivld !== 1'b0) $display("FAIL first_latency: ivld=%b want 0", bus.ivld); else n_pass++;
      cyc(1);
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (bus.ivld !== 1'b1 || bus.idat !== exp_d[i] || bus.iadr !== 16'(2 * i))
            $display("FAIL boot_seq%0d: got %b %h@%h want 1 %h@%h", i, bus.ivld, bus.idat, bus.iadr, exp_d[i], 16'(2 * i));
         else n_pass++;
         cyc(1);
      end
   endtask

   task automatic test_stall;
      bus.irdy = 1'b0;
      cyc(10);
      n_chk++; if (bus.fen !== 1'b0) $display("FAIL stall_fen: got %b want 0", bus.fen); else n_pass++;
      n_chk++; if (bus.ivld !== 1'b1) $display("FAIL stall_ivld: got %b want 1", bus.ivld); else n_pass++;
      bus.irdy = 1'b1; #1;
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (bus.ivld !== 1'b1) $display("FAIL stall_resume%0d: ivld=%b want 1", i, bus.ivld); else n_pass++;
         cyc(1);
      end
   endtask

   task automatic test_jmp_odd;
      bus.jmp = 1'b1; bus.jadr = 16'h0012;
      cyc(1);
      bus.jmp = 1'b0; #1;
      n_chk++;
      if (bus.ivld !== 1'b0 || bus.fen !== 1'b1 || bus.fadr !== 16'h0010)
         $display("FAIL jmp_issue: ivld=%b fen=%b fadr=%h want 0/1/0010", bus.ivld, bus.fen, bus.fadr);
      else n_pass++;
      cyc(1);
      n_chk++; if (bus.ivld !== 1'b0) $display("FAIL jmp_gap: ivld=%b want 0", bus.ivld); else n_pass++;
      cyc(1);
      n_chk++;
      if (bus.ivld !== 1'b1 || bus.idat !== 16'hBBBB || bus.iadr !== 16'h0012)
         $display("FAIL jmp_first: got %b %h@%h want 1 BBBB@0012", bus.ivld, bus.idat, bus.iadr);
      else n_pass++;
      cyc(1);
      n_chk++;
      if (bus.ivld !== 1'b1 || bus.idat !== rom_hw(16'h0014) || bus.iadr !== 16'h0014)
         $display("FAIL jmp_second: got %b %h@%h want 1 %h@0014", bus.ivld, bus.idat, bus.iadr, rom_hw(16'h0014));
      else n_pass++;
   endtask

   task automatic test_squash;
      logic [15:0] tgt;
      bit          found;
      for (int r = 0; r < 4; r++) begin
         found = 1'b0;
         for (int k = 0; k < 20 && !found; k++) begin
            if (bus.fen === 1'b1) found = 1'b1;
            else cyc(1);
         end
         n_chk++;
         if (!found) $display("FAIL squash_wait%0d: no fetch issued within 20 cycles", r); else n_pass++;
         cyc(1);
         tgt = 16'($urandom) & 16'hFFFE;
         bus.jmp = 1'b1; bus.jadr = tgt;
         cyc(1);
         bus.jmp = 1'b0; #1;
         n_chk++; if (bus.ivld !== 1'b0) $display("FAIL squash_gap1_%0d: ivld=%b want 0", r, bus.ivld); else n_pass++;
         cyc(1);
         n_chk++; if (bus.ivld !== 1'b0) $display("FAIL squash_gap2_%0d: ivld=%b want 0", r, bus.ivld); else n_pass++;
         cyc(1);
         n_chk++;
         if (bus.ivld !== 1'b1 || bus.iadr !== tgt || bus.idat !== rom_hw(tgt))
            $display("FAIL squash_first%0d: got %b %h@%h want 1 %h@%h", r, bus.ivld, bus.idat, bus.iadr, rom_hw(tgt), tgt);
         else n_pass++;
      end
   endtask

   task automatic test_wrap;
      bus.jmp = 1'b1; bus.jadr = 16'hFFFC;
      cyc(1);
      bus.jmp = 1'b0; #1;
      n_chk++;
      if (bus.fen !== 1'b1 || bus.fadr !== 16'hFFFC)
         $display("FAIL wrap_fadr0: fen=%b fadr=%h want 1/FFFC", bus.fen, bus.fadr);
      else n_pass++;
      cyc(1);
      n_chk++;
      if (bus.fen !== 1'b1 || bus.fadr !== 16'h0000)
         $display("FAIL wrap_fadr1: fen=%b fadr=%h want 1/0000", bus.fen, bus.fadr);
      else n_pass++;
      cyc(1);
      n_chk++; if (bus.iadr !== 16'hFFFC) $display("FAIL wrap_iadr0: got %h want FFFC", bus.iadr); else n_pass++;
      cyc(1);
      n_chk++; if (bus.iadr !== 16'hFFFE) $display("FAIL wrap_iadr1: got %h want FFFE", bus.iadr); else n_pass++;
      cyc(1);
      n_chk++;
      if (bus.iadr !== 16'h0000 || bus.idat !== 16'h1111)
         $display("FAIL wrap_iadr2: got %h@%h want 1111@0000", bus.idat, bus.iadr);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      bit prev_fen = 1'b0;
      bit found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (prev_fen && bus.ivld === 1'b1) found = 1'b1;
         else begin
            prev_fen = (bus.fen === 1'b1);
            cyc(1);
         end
      end
      n_chk++;
      if (!found) $display("FAIL rstmid_wait: no busy cycle found within 30 cycles"); else n_pass++;
      rst_n = 1'b0;
      cyc(1);
      n_chk++;
      if (bus.ivld !== 1'b0 || bus.fen !== 1'b0 || bus.iadr !== RV || bus.idat !== 16'h0)
         $display("FAIL rstmid_state: ivld=%b fen=%b iadr=%h idat=%h want 0/0/%h/0000", bus.ivld, bus.fen, bus.iadr, bus.idat, RV);
      else n_pass++;
      cyc(1);
      rst_n = 1'b1; #1;
      n_chk++;
      if (bus.fen !== 1'b1 || bus.fadr !== RV)
         $display("FAIL rstmid_resume: fen=%b fadr=%h want 1/%h", bus.fen, bus.fadr, RV);
      else n_pass++;
      cyc(2);
      n_chk++;
      if (bus.ivld !== 1'b1 || bus.iadr !== RV || bus.idat !== rom_hw(RV))
         $display("FAIL rstmid_first: got %b %h@%h want 1 %h@%h", bus.ivld, bus.idat, bus.iadr, rom_hw(RV), RV);
      else n_pass++;
   endtask

   task automatic test_random;
      int acc0;
      acc0 = n_acc;
      for (int i = 0; i < 1500; i++) begin
         bus.irdy = ($urandom_range(0, 3) != 0);
         bus.jmp  = ($urandom_range(0, 15) == 0);
         bus.jadr = 16'($urandom);
         cyc(1);
      end
      bus.jmp = 1'b0; bus.irdy = 1'b1;
      cyc(8);
      n_chk++;
      if (n_acc - acc0 < 300) $display("FAIL random_throughput: accepted %0d want >= 300", n_acc - acc0);
      else n_pass++;
   endtask

   initial begin
      bus.jmp = 1'b0; bus.jadr = '0; bus.irdy = 1'b0;
      test_reset();
      test_stall();
      test_jmp_odd();
      test_squash();
      test_wrap();
      test_reset_mid();
      test_random();
      n_chk  += mon_chk;
      n_pass += mon_pass;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
